// File: rtl/fft_frame_capture.sv
// fft_frame_capture: AXI-stream sink that captures one FFT output frame into
// a simple dual-port RAM, checks tlast framing, and offers a random-access
// read port with one cycle of latency.
module fft_frame_capture #(
    parameter  int unsigned FRAME_LEN = 4096,
    parameter  int unsigned DATA_W    = 64,
    localparam int unsigned ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_data_tdata,
    input  logic              s_axis_data_tvalid,
    output logic              s_axis_data_tready,
    input  logic              s_axis_data_tlast,
    input  logic              arm,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W:0]   sample_count,
    output logic              err_tlast_early,
    output logic              err_tlast_missing,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              early_q, early_d;
    logic              miss_q, miss_d;
    logic              tready_q, tready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs_c;
    logic              wr_en_c;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    logic [DATA_W-1:0] mem [FRAME_LEN];

    assign hs_c = s_axis_data_tvalid & tready_q;

    // State and registered status outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            early_q  <= 1'b0;
            miss_q   <= 1'b0;
            tready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            early_q  <= early_d;
            miss_q   <= miss_d;
            tready_q <= tready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next state, count and sticky framing errors; status follows next state
    // so tready drops on the same edge that takes the final sample.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        early_d = early_q;
        miss_d  = miss_q;
        wr_en_c = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d = S_CAPTURE;
                    count_d = '0;
                    early_d = 1'b0;
                    miss_d  = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (hs_c) begin
                    wr_en_c = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    if (s_axis_data_tlast || (count_q == LAST_IDX)) begin
                        state_d = S_DONE;
                    end
                    if (s_axis_data_tlast && (count_q != LAST_IDX)) begin
                        early_d = 1'b1;
                    end
                    if (!s_axis_data_tlast && (count_q == LAST_IDX)) begin
                        miss_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        tready_d = (state_d == S_CAPTURE);
        busy_d   = (state_d == S_CAPTURE);
        done_d   = (state_d == S_DONE);
    end

    // Frame RAM write port; contents survive reset.
    always_ff @(posedge aclk) begin
        if (wr_en_c) begin
            mem[count_q[ADDR_W-1:0]] <= s_axis_data_tdata;
        end
    end

    // Registered read port, read-first on a same-address collision.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= mem[rd_addr];
            end
        end
    end

    assign s_axis_data_tready = tready_q;
    assign busy               = busy_q;
    assign frame_done         = done_q;
    assign sample_count       = count_q;
    assign err_tlast_early    = early_q;
    assign err_tlast_missing  = miss_q;
    assign rd_data            = rd_data_q;
    assign rd_valid           = rd_valid_q;

endmodule

// File: tb/tb_fft_frame_capture.sv
// tb_fft_frame_capture: directed bench for fft_frame_capture with a small
// (8-sample) and a full-size (4096-sample) instance; read data is checked
// through a scoreboard queue against a bench-side RAM model.
module tb_fft_frame_capture;

    localparam int unsigned SL = 8;
    localparam int unsigned SA = 3;
    localparam int unsigned BL = 4096;
    localparam int unsigned BA = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [63:0]   s_tdata;
    logic          s_tvalid, s_tready, s_tlast, s_arm, s_busy, s_done;
    logic [SA:0]   s_cnt;
    logic          s_early, s_miss, s_rd_en, s_rd_valid;
    logic [SA-1:0] s_rd_addr;
    logic [63:0]   s_rd_data;

    logic [63:0]   b_tdata;
    logic          b_tvalid, b_tready, b_tlast, b_arm, b_busy, b_done;
    logic [BA:0]   b_cnt;
    logic          b_early, b_miss, b_rd_en, b_rd_valid;
    logic [BA-1:0] b_rd_addr;
    logic [63:0]   b_rd_data;

    fft_frame_capture #(.FRAME_LEN(SL), .DATA_W(64)) u_small (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid),
        .s_axis_data_tready(s_tready), .s_axis_data_tlast(s_tlast),
        .arm(s_arm), .busy(s_busy), .frame_done(s_done), .sample_count(s_cnt),
        .err_tlast_early(s_early), .err_tlast_missing(s_miss),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid)
    );

    fft_frame_capture #(.FRAME_LEN(BL), .DATA_W(64)) u_big (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_data_tdata(b_tdata), .s_axis_data_tvalid(b_tvalid),
        .s_axis_data_tready(b_tready), .s_axis_data_tlast(b_tlast),
        .arm(b_arm), .busy(b_busy), .frame_done(b_done), .sample_count(b_cnt),
        .err_tlast_early(b_early), .err_tlast_missing(b_miss),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
    );

    int          tests  = 0;
    int          failed = 0;
    logic [63:0] exp_q[$];
    logic [63:0] m8[SL];
    logic [63:0] mb[BL];
    int unsigned cnt8;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm8();
        s_arm = 1'b1;
        tick();
        s_arm = 1'b0;
        cnt8  = 0;
    endtask

    // Present one sample until accepted (bounded); record accepted data in the model.
    task automatic send8(input logic [63:0] d, input logic last);
        bit ok;
        ok       = 1'b0;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            ok = s_tready;
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (ok) begin
            m8[cnt8 % SL] = d;
            cnt8++;
        end else begin
            chk("send_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic st8(input logic busy, input logic done, input logic rdy,
                       input int unsigned cnt, input logic e, input logic m);
        chk("busy", s_busy, busy);
        chk("frame_done", s_done, done);
        chk("tready", s_tready, rdy);
        chk("sample_count", s_cnt, 64'(cnt));
        chk("err_tlast_early", s_early, e);
        chk("err_tlast_missing", s_miss, m);
    endtask

    // Back-to-back reads of addresses 0..n-1, then one idle cycle.
    task automatic read8_all(input int n);
        for (int i = 0; i < n; i++) begin
            s_rd_en   = 1'b1;
            s_rd_addr = SA'(i);
            exp_q.push_back(m8[i]);
            tick();
            chk("rd_valid", s_rd_valid, 1'b1);
            chk("rd_data", s_rd_data, exp_q.pop_front());
        end
        s_rd_en = 1'b0;
        tick();
        chk("rd_valid_idle", s_rd_valid, 1'b0);
        chk("rd_data_hold", s_rd_data, m8[n-1]);
    endtask

    initial begin
        rst_n = 1'b0;
        s_tdata = '0; s_tvalid = 0; s_tlast = 0; s_arm = 0; s_rd_en = 0; s_rd_addr = '0;
        b_tdata = '0; b_tvalid = 0; b_tlast = 0; b_arm = 0; b_rd_en = 0; b_rd_addr = '0;
        cnt8 = 0;
        repeat (3) tick();

        // Reset state
        st8(0, 0, 0, 0, 0, 0);
        chk("rst_rd_data", s_rd_data, 64'd0);
        chk("rst_rd_valid", s_rd_valid, 1'b0);
        chk("rst_big_cnt", b_cnt, 64'd0);
        chk("rst_big_tready", b_tready, 1'b0);
        rst_n = 1'b1;
        tick();
        st8(0, 0, 0, 0, 0, 0);

        // Clean frame
        arm8();
        st8(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) send8(64'(i), i == 7);
        st8(0, 1, 0, 8, 0, 0);
        read8_all(8);

        // Gaps between samples
        arm8();
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send8({$urandom, $urandom}, i == 7);
        end
        st8(0, 1, 0, cnt8, 0, 0);
        chk("gap_count", s_cnt, 64'd8);
        read8_all(8);

        // Early tlast on sample 4; later samples refused
        arm8();
        for (int i = 0; i < 5; i++) send8(64'(i), i == 4);
        st8(0, 1, 0, 5, 1, 0);
        s_tvalid = 1'b1;
        s_tdata  = 64'd5;
        repeat (3) begin
            tick();
            chk("early_no_accept_tready", s_tready, 1'b0);
            chk("early_no_accept_cnt", s_cnt, 64'd5);
        end
        s_tvalid = 1'b0;
        read8_all(8);

        // Missing tlast; re-arm from DONE clears the early flag
        arm8();
        st8(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) send8(64'h100 + 64'(i), 1'b0);
        st8(0, 1, 0, 8, 0, 1);
        s_tvalid = 1'b1;
        s_tdata  = 64'h1ff;
        repeat (3) begin
            tick();
            chk("ninth_pending_tready", s_tready, 1'b0);
            chk("ninth_pending_cnt", s_cnt, 64'd8);
        end
        s_tvalid = 1'b0;
        read8_all(8);

        // Re-arm, then asynchronous reset mid-capture
        arm8();
        st8(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) send8(64'hAB00 + 64'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        st8(0, 0, 0, 0, 0, 0);
        chk("async_rd_valid", s_rd_valid, 1'b0);
        chk("async_rd_data", s_rd_data, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        st8(0, 0, 0, 0, 0, 0);

        // Full frame after reset; first write collides with a read of address 0
        arm8();
        s_rd_en   = 1'b1;
        s_rd_addr = '0;
        exp_q.push_back(m8[0]);
        send8(64'hC0DE_0000, 1'b0);
        s_rd_en = 1'b0;
        chk("collision_rd_valid", s_rd_valid, 1'b1);
        chk("collision_old_data", s_rd_data, exp_q.pop_front());
        for (int i = 1; i < 8; i++) send8(64'hC0DE_0000 + 64'(i), i == 7);
        st8(0, 1, 0, 8, 0, 0);
        read8_all(8);

        // Full-length frame on the 4096-sample instance
        b_arm = 1'b1;
        tick();
        b_arm = 1'b0;
        chk("big_tready", b_tready, 1'b1);
        for (int i = 0; i < BL; i++) begin
            mb[i]    = {$urandom, $urandom};
            b_tdata  = mb[i];
            b_tlast  = (i == BL - 1);
            b_tvalid = 1'b1;
            if (!b_tready) begin
                chk("big_stall", 64'(i), 64'(BL));
                break;
            end
            tick();
        end
        b_tvalid = 1'b0;
        b_tlast  = 1'b0;
        chk("big_count", b_cnt, 64'(BL));
        chk("big_done", b_done, 1'b1);
        chk("big_tready_low", b_tready, 1'b0);
        chk("big_early", b_early, 1'b0);
        chk("big_missing", b_miss, 1'b0);
        for (int i = 0; i < BL; i++) begin
            b_rd_en   = 1'b1;
            b_rd_addr = BA'(i);
            exp_q.push_back(mb[i]);
            tick();
            chk("big_rd_data", b_rd_data, exp_q.pop_front());
        end
        b_rd_en = 1'b0;
        tick();
        chk("big_rd_valid_idle", b_rd_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fft_frame_capture.md
Name: fft_frame_capture

Overview:
- AXI-stream sink that sits on the master data output of the floating-point FFT core (k_floatfft).
- Accepts one complete transform frame of 64-bit complex samples: {imag[63:32], real[31:0]}, IEEE-754 single precision each.
- Stores the frame in an internal RAM and checks tlast framing.
- Exposes a random-access read port so a host or readback logic can fetch bins after capture.

Parameters:
- FRAME_LEN, 4096, samples per frame; must be a power of two, minimum 8.
- DATA_W, 64, sample width in bits (complex pair).
- ADDR_W, $clog2(FRAME_LEN), derived localparam; not overridable.

Ports:
- aclk  input  1  single clock; all logic is rising-edge.
- aresetn  input  1  asynchronous active-low reset.
- s_axis_data_tdata  input  DATA_W  sample from the FFT output stream.
- s_axis_data_tvalid  input  1  sample valid.
- s_axis_data_tready  output  1  capture ready.
- s_axis_data_tlast  input  1  last sample of frame.
- arm  input  1  single-cycle pulse that starts a capture.
- busy  output  1  high while in CAPTURE.
- frame_done  output  1  high while in DONE.
- sample_count  output  ADDR_W+1  number of samples written in the current or last frame.
- err_tlast_early  output  1  sticky: tlast arrived before sample FRAME_LEN-1.
- err_tlast_missing  output  1  sticky: sample FRAME_LEN-1 arrived without tlast.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_W  read address (bin index).
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  qualifies rd_data.

Behaviour:
- Reset (aresetn low, asynchronous): state=IDLE. All outputs are 0: tready, busy, frame_done, sample_count, both error flags, rd_data, rd_valid. RAM contents are not cleared. Reset mid-capture abandons the frame.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - tready=0.
  - arm=1 -> CAPTURE next cycle; sample_count cleared to 0; error flags cleared.
- CAPTURE:
  - busy=1, tready=1 (registered, asserted the cycle after arm).
  - Handshake (tvalid & tready) writes tdata to RAM[sample_count] and increments sample_count.
  - Handshake with tlast=1 at sample_count==FRAME_LEN-1 -> DONE, clean frame.
  - Handshake with tlast=1 at sample_count<FRAME_LEN-1 -> DONE with err_tlast_early=1. sample_count holds the truncated length.
  - Handshake with tlast=0 at sample_count==FRAME_LEN-1 -> DONE with err_tlast_missing=1. Any further samples are not accepted.
  - tready drops in the same edge as the final write, so the final sample is the last one accepted.
  - tvalid low stalls the capture indefinitely; no timeout.
  - arm is ignored in CAPTURE.
- DONE:
  - frame_done=1, tready=0.
  - Outputs hold: sample_count, error flags.
  - arm=1 -> CAPTURE, clearing count and flags (re-arm). The old frame is overwritten progressively.
- Read port:
  - Operates in every state.
  - rd_en at cycle N -> rd_data=RAM[rd_addr] and rd_valid=1 at cycle N+1. rd_valid=0 when rd_en was 0; rd_data holds its last value.
  - Read/write collision on the same address in the same cycle returns the old data (read-first).
  - Addresses >= sample_count return stale RAM contents; this is not flagged.
- The RAM is inferred as simple dual-port block RAM: one write port, one read port, 1-cycle read latency.
- No arithmetic on sample contents; data is bit-exact pass-through.
- sample_count width ADDR_W+1 holds FRAME_LEN exactly with no wrap.

Test Plan:
- Use FRAME_LEN=8 unless noted.
- Clean frame: reset, arm, stream tdata=i for i=0..7 with tlast on i=7 -> frame_done=1 one cycle after the last handshake, sample_count=8, both errors 0, tready=0. Reading addr 0..7 returns 0..7 with 1-cycle latency, rd_valid pulses with each rd_en.
- Backpressure/gaps: tvalid toggled 1-0-1 with random gaps -> exactly 8 writes, RAM contents match in order, no samples dropped or duplicated.
- Early tlast: tlast on sample 4 (tdata=4) -> frame_done=1, err_tlast_early=1, sample_count=5, tready=0. Samples 5..7 presented afterwards are not accepted.
- Missing tlast: 8 samples with no tlast -> err_tlast_missing=1, sample_count=8, tready low after sample 7; a 9th sample stays pending.
- Re-arm and reset: from DONE with err set, pulse arm -> flags cleared, busy=1, new frame overwrites data. Assert aresetn=0 after 3 samples -> all outputs 0 immediately, state IDLE; a new arm then captures a full frame correctly.
- Full length: FRAME_LEN=4096, 4096 samples of 64-bit patterns, tlast on the last -> sample_count=4096, all 4096 read back bit-exact.
